// File: rtl/vga_timing_pkg.sv
// Shared timing constants, axis segment type and helpers for the VGA timing generator.
package vga_timing_pkg;

    // Position of a count inside one axis period, in scan order.
    typedef enum logic [1:0] {
        SEG_ACTIVE = 2'd0,
        SEG_FP     = 2'd1,
        SEG_SYNC   = 2'd2,
        SEG_BP     = 2'd3
    } seg_e;

    // 640x480 @ 60 Hz, 25 MHz pixel clock (800 x 525 totals).
    localparam int unsigned VGA640_PIX_CLK_HZ = 25_000_000;
    localparam int unsigned VGA640_H_ACTIVE   = 640;
    localparam int unsigned VGA640_H_FP       = 16;
    localparam int unsigned VGA640_H_SYNC     = 96;
    localparam int unsigned VGA640_H_BP       = 48;
    localparam int unsigned VGA640_V_ACTIVE   = 480;
    localparam int unsigned VGA640_V_FP       = 10;
    localparam int unsigned VGA640_V_SYNC     = 2;
    localparam int unsigned VGA640_V_BP       = 33;

    // 800x600 @ 72 Hz, 50 MHz pixel clock (1040 x 666 totals), positive syncs.
    localparam int unsigned VGA800_PIX_CLK_HZ = 50_000_000;
    localparam int unsigned VGA800_H_ACTIVE   = 800;
    localparam int unsigned VGA800_H_FP       = 56;
    localparam int unsigned VGA800_H_SYNC     = 120;
    localparam int unsigned VGA800_H_BP       = 64;
    localparam int unsigned VGA800_V_ACTIVE   = 600;
    localparam int unsigned VGA800_V_FP       = 37;
    localparam int unsigned VGA800_V_SYNC     = 6;
    localparam int unsigned VGA800_V_BP       = 23;

    // Length of one full axis period.
    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    // Smallest counter width able to hold total-1.
    function automatic int unsigned axis_width(input int unsigned total);
        int unsigned w;
        w = 1;
        while ((longint'(1) << w) < longint'(total)) w++;
        return w;
    endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One scan axis: a wrapping counter with registered sync output and
// look-ahead active/wrap decode so the parent can register its flags in step.
module vga_axis_ctr
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter bit          POL    = 1'b0,
    parameter int unsigned CW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_sync,
    output logic          o_active_nxt,
    output logic          o_wrap
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    // All boundaries are held one bit wider than the counter so no sum wraps.
    localparam logic [CW:0] LAST     = (CW+1)'(TOTAL - 1);
    localparam logic [CW:0] ONE      = (CW+1)'(1);
    localparam logic [CW:0] FP_START = (CW+1)'(ACTIVE);
    localparam logic [CW:0] SY_START = (CW+1)'(ACTIVE + FP);
    localparam logic [CW:0] BP_START = (CW+1)'(ACTIVE + FP + SYNC);

    // Reject timings that cannot be represented or have empty porch/sync segments.
    if (FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_segment
        $error("vga_axis_ctr: porch and sync widths must each be at least 1");
    end
    if (longint'(TOTAL) - 1 > (longint'(1) << CW) - 1) begin : g_bad_width
        $error("vga_axis_ctr: TOTAL-1 does not fit in CW bits");
    end

    logic [CW-1:0] r_count;
    logic          r_sync;
    logic [CW:0]   w_count_ext;
    logic [CW:0]   w_next_ext;
    logic          w_wrap;
    seg_e          w_seg;

    // Next count and the segment that next count falls in.
    always_comb begin
        // NOTE: every signal written here is given a value before any branch, so no latch is inferred.
        w_count_ext = {1'b0, r_count};
        w_wrap      = i_en && (w_count_ext == LAST);
        w_next_ext  = w_count_ext;
        w_seg       = SEG_BP;
        if (w_wrap) begin
            w_next_ext = '0;
        end else if (i_en) begin
            w_next_ext = w_count_ext + ONE;
        end
        if (w_next_ext < FP_START) begin
            w_seg = SEG_ACTIVE;
        end else if (w_next_ext < SY_START) begin
            w_seg = SEG_FP;
        end else if (w_next_ext < BP_START) begin
            w_seg = SEG_SYNC;
        end
    end

    // Count register and sync level, both loaded from the next-count decode.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments; reset is synchronous and wins over the enable.
        if (reset) begin
            r_count <= LAST[CW-1:0];
            r_sync  <= ~POL;
        end else begin
            r_count <= w_next_ext[CW-1:0];
            r_sync  <= (w_seg == SEG_SYNC) ? POL : ~POL;
        end
    end

    assign o_count      = r_count;
    assign o_sync       = r_sync;
    assign o_active_nxt = (w_seg == SEG_ACTIVE);
    assign o_wrap       = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal and vertical axis counters chained by the
// horizontal wrap, with all outputs registered so they describe the same pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
    parameter int unsigned H_FP     = VGA640_H_FP,
    parameter int unsigned H_SYNC   = VGA640_H_SYNC,
    parameter int unsigned H_BP     = VGA640_H_BP,
    parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
    parameter int unsigned V_FP     = VGA640_V_FP,
    parameter int unsigned V_SYNC   = VGA640_V_SYNC,
    parameter int unsigned V_BP     = VGA640_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clk25M,
    input  logic          reset,
    input  logic          pix_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          HS,
    output logic          VS,
    output logic          vga_on,
    output logic          line_start,
    output logic          frame_start
);

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_h_active_nxt;
    logic w_v_active_nxt;
    logic r_vga_on;
    logic r_line_start;
    logic r_frame_start;

    // Horizontal axis advances on every enabled pixel.
    vga_axis_ctr #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .CW     (CW)
    ) u_h_ctr (
        .clk          (clk25M),
        .reset        (reset),
        .i_en         (pix_en),
        .o_count      (hcount),
        .o_sync       (HS),
        .o_active_nxt (w_h_active_nxt),
        .o_wrap       (w_h_wrap)
    );

    // Vertical axis advances only when the line wraps.
    vga_axis_ctr #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .CW     (CW)
    ) u_v_ctr (
        .clk          (clk25M),
        .reset        (reset),
        .i_en         (w_h_wrap),
        .o_count      (vcount),
        .o_sync       (VS),
        .o_active_nxt (w_v_active_nxt),
        .o_wrap       (w_v_wrap)
    );

    // Visible-area flag and start strobes, registered alongside the counters.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            r_vga_on      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_vga_on      <= w_h_active_nxt & w_v_active_nxt;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign vga_on      = r_vga_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three generator instances (640x480 defaults, 800x600
// with positive syncs, and a tiny raster for whole-frame behaviour) share one
// stimulus; a behavioural model scoreboards every cycle of every instance.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        on;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        bit   rst;
        bit   en;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic reset  = 1'b1;
    logic pix_en = 1'b0;

    logic [9:0]  hc_a, vc_a;
    logic [10:0] hc_b, vc_b;
    logic [3:0]  hc_c, vc_c;
    logic hs_a, vs_a, on_a, ls_a, fs_a;
    logic hs_b, vs_b, on_b, ls_b, fs_b;
    logic hs_c, vs_c, on_c, ls_c, fs_c;

    vga_timing_gen u_dut_a (
        .clk25M (clk), .reset (reset), .pix_en (pix_en),
        .hcount (hc_a), .vcount (vc_a), .HS (hs_a), .VS (vs_a),
        .vga_on (on_a), .line_start (ls_a), .frame_start (fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (VGA800_H_ACTIVE), .H_FP (VGA800_H_FP), .H_SYNC (VGA800_H_SYNC), .H_BP (VGA800_H_BP),
        .V_ACTIVE (VGA800_V_ACTIVE), .V_FP (VGA800_V_FP), .V_SYNC (VGA800_V_SYNC), .V_BP (VGA800_V_BP),
        .HS_POL (1'b1), .VS_POL (1'b1), .CW (11)
    ) u_dut_b (
        .clk25M (clk), .reset (reset), .pix_en (pix_en),
        .hcount (hc_b), .vcount (vc_b), .HS (hs_b), .VS (vs_b),
        .vga_on (on_b), .line_start (ls_b), .frame_start (fs_b)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (5), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .HS_POL (1'b1), .VS_POL (1'b0), .CW (4)
    ) u_dut_c (
        .clk25M (clk), .reset (reset), .pix_en (pix_en),
        .hcount (hc_c), .vcount (vc_c), .HS (hs_c), .VS (vs_c),
        .vga_on (on_c), .line_start (ls_c), .frame_start (fs_c)
    );

    int n_checks = 0;
    int n_errors = 0;

    cfg_t cfg [3];
    int   mh  [3];
    int   mv  [3];
    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t mk(input int h, input int v, input bit hs, input bit vs,
                                input bit on, input bit ls, input bit fs);
        obs_t o;
        o.h = 11'(h); o.v = 11'(v);
        o.hs = hs; o.vs = vs; o.on = on; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic obs_t model_obs(input cfg_t c, input int h, input int v, input bit ls, input bit fs);
        bit hs, vs;
        hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : !c.hpol;
        vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : !c.vpol;
        return mk(h, v, hs, vs, (h < c.ha) && (v < c.va), ls, fs);
    endfunction

    function automatic obs_t dut_obs(input int k);
        obs_t o;
        o = '0;
        case (k)
            0:       o = mk(int'(hc_a), int'(vc_a), hs_a, vs_a, on_a, ls_a, fs_a);
            1:       o = mk(int'(hc_b), int'(vc_b), hs_b, vs_b, on_b, ls_b, fs_b);
            default: o = mk(int'(hc_c), int'(vc_c), hs_c, vs_c, on_c, ls_c, fs_c);
        endcase
        return o;
    endfunction

    // Advance the reference model by one edge and queue the expected outputs.
    task automatic model_step(input bit rst, input bit en);
        for (int k = 0; k < 3; k++) begin
            int ht, vt;
            bit ls, fs;
            obs_t e;
            ht = cfg[k].ha + cfg[k].hfp + cfg[k].hsw + cfg[k].hbp;
            vt = cfg[k].va + cfg[k].vfp + cfg[k].vsw + cfg[k].vbp;
            ls = 1'b0;
            fs = 1'b0;
            if (rst) begin
                mh[k] = ht - 1;
                mv[k] = vt - 1;
            end else if (en) begin
                if (mh[k] == ht - 1) begin
                    mh[k] = 0;
                    mv[k] = (mv[k] == vt - 1) ? 0 : mv[k] + 1;
                    ls = 1'b1;
                    fs = (mv[k] == 0);
                end else begin
                    mh[k] = mh[k] + 1;
                end
            end
            e = model_obs(cfg[k], mh[k], mv[k], ls, fs);
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // One clock: drive on the falling edge, compare the scoreboard just after the rising edge.
    task automatic step(input bit rst, input bit en);
        obs_t e;
        @(negedge clk);
        reset  = rst;
        pix_en = en;
        model_step(rst, en);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            bit empty;
            e = '0;
            empty = 1'b0;
            case (k)
                0:       if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
                1:       if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
                default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
            endcase
            if (empty) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb%0d: scoreboard queue empty", k);
            end else begin
                check($sformatf("sb%0d", k), 64'(dut_obs(k)), 64'(e));
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        int hs_lo_cnt, hs_lo_min, hs_lo_max, ls_cnt;
        int b_hs_cnt, b_hs_min, b_hs_max;
        int fs_cnt, on_cnt, vs_lo_cnt, fs_first, fs_gap, ls_idle;

        cfg[0] = '{VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP,
                   VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP, 1'b0, 1'b0};
        cfg[1] = '{VGA800_H_ACTIVE, VGA800_H_FP, VGA800_H_SYNC, VGA800_H_BP,
                   VGA800_V_ACTIVE, VGA800_V_FP, VGA800_V_SYNC, VGA800_V_BP, 1'b1, 1'b1};
        cfg[2] = '{8, 2, 3, 2, 5, 1, 2, 2, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            mh[k] = 0;
            mv[k] = 0;
        end

        // Reset state, first enable, hold and reset priority on the 640x480 instance.
        tbl[0] = '{1'b1, 1'b0, mk(799, 524, 1, 1, 0, 0, 0)};
        tbl[1] = '{1'b0, 1'b1, mk(0,   0,   1, 1, 1, 1, 1)};
        tbl[2] = '{1'b0, 1'b0, mk(0,   0,   1, 1, 1, 0, 0)};
        tbl[3] = '{1'b0, 1'b1, mk(1,   0,   1, 1, 1, 0, 0)};
        tbl[4] = '{1'b1, 1'b1, mk(799, 524, 1, 1, 0, 0, 0)};
        tbl[5] = '{1'b0, 1'b1, mk(0,   0,   1, 1, 1, 1, 1)};
        tbl[6] = '{1'b0, 1'b1, mk(1,   0,   1, 1, 1, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst, tbl[i].en);
            check($sformatf("vec%0d", i), 64'(dut_obs(0)), 64'(tbl[i].exp));
        end

        // One full 640 line plus a full 800x600 line.
        hs_lo_cnt = 0; hs_lo_min = 9999; hs_lo_max = -1; ls_cnt = 0;
        b_hs_cnt  = 0; b_hs_min  = 9999; b_hs_max  = -1;
        step(1'b1, 1'b0);
        for (int i = 1; i <= 1041; i++) begin
            step(1'b0, 1'b1);
            if (i <= 800) begin
                if (hs_a == 1'b0) begin
                    hs_lo_cnt++;
                    if (int'(hc_a) < hs_lo_min) hs_lo_min = int'(hc_a);
                    if (int'(hc_a) > hs_lo_max) hs_lo_max = int'(hc_a);
                end
                if (ls_a) ls_cnt++;
            end
            if (i <= 1040 && hs_b == 1'b1) begin
                b_hs_cnt++;
                if (int'(hc_b) < b_hs_min) b_hs_min = int'(hc_b);
                if (int'(hc_b) > b_hs_max) b_hs_max = int'(hc_b);
            end
            if (i == 640) check("a_on_at_639", 64'(dut_obs(0)), 64'(mk(639, 0, 1, 1, 1, 0, 0)));
            if (i == 641) check("a_on_fall_640", 64'(dut_obs(0)), 64'(mk(640, 0, 1, 1, 0, 0, 0)));
            if (i == 801) check("a_line_wrap", 64'(dut_obs(0)), 64'(mk(0, 1, 1, 1, 1, 1, 0)));
            if (i == 1041) check("b_line_wrap", 64'(dut_obs(1)), 64'(mk(0, 1, 0, 0, 1, 1, 0)));
        end
        check("a_hs_low_cycles", 64'(hs_lo_cnt), 64'(96));
        check("a_hs_low_first",  64'(hs_lo_min), 64'(656));
        check("a_hs_low_last",   64'(hs_lo_max), 64'(751));
        check("a_line_starts",   64'(ls_cnt),    64'(1));
        check("b_hs_high_cycles", 64'(b_hs_cnt), 64'(120));
        check("b_hs_high_first",  64'(b_hs_min), 64'(856));
        check("b_hs_high_last",   64'(b_hs_max), 64'(975));

        // Three whole frames of the small raster (15 x 10).
        fs_cnt = 0; on_cnt = 0; vs_lo_cnt = 0;
        step(1'b1, 1'b0);
        for (int i = 1; i <= 450; i++) begin
            step(1'b0, 1'b1);
            if (fs_c) fs_cnt++;
            if (on_c) on_cnt++;
            if (vs_c == 1'b0) vs_lo_cnt++;
            if (i == 76)  check("c_wrap_to_v5",  64'(dut_obs(2)), 64'(mk(0, 5, 0, 1, 0, 1, 0)));
            if (i == 151) check("c_frame_wrap",  64'(dut_obs(2)), 64'(mk(0, 0, 0, 1, 1, 1, 1)));
        end
        check("c_frame_starts", 64'(fs_cnt),    64'(3));
        check("c_on_cycles",    64'(on_cnt),    64'(120));
        check("c_vs_low_cycles", 64'(vs_lo_cnt), 64'(90));

        // Alternating enable: frame period doubles and strobes never appear on idle cycles.
        fs_cnt = 0; fs_first = -1; fs_gap = -1; ls_idle = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(1'b0, (i % 2) == 0);
            if (fs_c) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                else if (fs_gap < 0) fs_gap = i - fs_first;
            end
            if ((i % 2) == 1 && (ls_c || fs_c || ls_a || fs_a)) ls_idle++;
        end
        check("alt_frame_starts", 64'(fs_cnt),  64'(2));
        check("alt_frame_period", 64'(fs_gap),  64'(300));
        check("alt_idle_strobes", 64'(ls_idle), 64'(0));

        // Mid-line reset on the 640x480 instance.
        step(1'b1, 1'b0);
        for (int i = 0; i < 301; i++) step(1'b0, 1'b1);
        check("a_pre_reset_pos", 64'(dut_obs(0)), 64'(mk(300, 0, 1, 1, 1, 0, 0)));
        step(1'b1, 1'b1);
        check("a_mid_reset",     64'(dut_obs(0)), 64'(mk(799, 524, 1, 1, 0, 0, 0)));
        step(1'b0, 1'b1);
        check("a_after_reset",   64'(dut_obs(0)), 64'(mk(0, 0, 1, 1, 1, 1, 1)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 Parameter HS_POL, default 0: asserted HS level (0 = active-low).
REQ-010 Parameter VS_POL, default 0: asserted VS level.
REQ-011 Parameter CW, default 10: counter width.
REQ-012 clk25M  in  1  pixel-domain clock; the block has one clock.
REQ-013 reset  in  1  synchronous, active-high reset.
REQ-014 pix_en  in  1  pixel advance enable; when high, the counters step on that clock edge.
REQ-015 hcount  out  CW  current pixel column.
REQ-016 vcount  out  CW  current line.
REQ-017 HS  out  1  horizontal sync, polarity set by HS_POL.
REQ-018 VS  out  1  vertical sync, polarity set by VS_POL.
REQ-019 vga_on  out  1  high while (hcount, vcount) is in the visible area.
REQ-020 line_start  out  1  single-cycle strobe when hcount becomes 0.
REQ-021 frame_start  out  1  single-cycle strobe when (hcount, vcount) becomes (0, 0).

Function
REQ-022 Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-023 Line order: active, then front porch, then sync, then back porch; frame order is the same.
REQ-024 Edge with pix_en=1: hcount increments; at H_TOTAL-1, hcount wraps to 0.
REQ-025 vcount increments only on an hcount wrap; at V_TOTAL-1 with an hcount wrap, vcount wraps to 0.
REQ-026 Edge with pix_en=0: all counters, HS, VS and vga_on hold; line_start and frame_start are 0.
REQ-027 HS = HS_POL iff hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise HS = ~HS_POL.
REQ-028 VS = VS_POL iff vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; otherwise VS = ~VS_POL.
REQ-029 vga_on = 1 iff hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-030 All outputs are registered; HS, VS and vga_on are decoded from the next-count values, so every output describes the same pixel in the same cycle (zero skew).
REQ-031 line_start = 1 for exactly the one cycle after an edge that loads hcount=0; frame_start also requires vcount=0.
REQ-032 Comparisons use CW+1-bit arithmetic, so no sum wraps.
REQ-033 Elaboration fails ($error) if any porch or sync parameter is < 1, or if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1.

Reset
REQ-034 reset has priority over pix_en and applies on the next clk25M edge, including mid-line and mid-frame.
REQ-035 Reset values: hcount=H_TOTAL-1, vcount=V_TOTAL-1, HS=~HS_POL, VS=~VS_POL, vga_on=0, line_start=0, frame_start=0.
REQ-036 The first pix_en=1 edge after reset loads (0, 0) and asserts line_start and frame_start.

Structure
REQ-037 Package vga_timing_pkg holds the default 640x480@60 constants and an 800x600@72 set (1040 x 666 totals, 50 MHz pixel clock).
REQ-038 Sub-module vga_axis_ctr, a generic wrap counter with sync/active decode and wrap flag, is instantiated twice: H (enable = pix_en) and V (enable = H wrap).

Verification
REQ-039 Reset, then 800 pix_en cycles -> hcount 0..799; HS low exactly for hcount 656..751 (96 cycles); line_start on the first cycle only.
REQ-040 420000 enabled cycles -> one frame_start per 420000 cycles; VS low only for vcount 490..491; 307200 vga_on cycles per frame.
REQ-041 pix_en alternating 1/0 -> outputs change only after enabled edges; frame period 840000 clocks; strobes are one cycle wide.
REQ-042 reset at (300, 200) -> next cycle (799, 524), vga_on=0, HS=VS=1; first enable gives (0, 0) with frame_start=1.
REQ-043 800x600@72 set with HS_POL=VS_POL=1 -> H_TOTAL 1040; HS high for hcount 856..975; VS high for vcount 637..642.
REQ-044 At each wrap, check (799, 479)->(0, 480), (799, 524)->(0, 0) with frame_start, and vga_on falling at hcount 640.
